// File: rtl/clock_pkg.sv
// Shared types and codes for the HH:MM:SS time-setting controller.
package clock_pkg;

  typedef logic [7:0] bcd2_t;

  typedef enum logic [1:0] {RUN, SET_HH, SET_MM, SET_SS} clk_mode_t;

  localparam logic [1:0] BLINK_HH   = 2'b00;
  localparam logic [1:0] BLINK_MM   = 2'b01;
  localparam logic [1:0] BLINK_SS   = 2'b10;
  localparam logic [1:0] BLINK_NONE = 2'b11;

  function automatic logic [1:0] blink_code(input clk_mode_t m);
    case (m)
      SET_HH:  return BLINK_HH;
      SET_MM:  return BLINK_MM;
      SET_SS:  return BLINK_SS;
      default: return BLINK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bcd2_updown.sv
// Two-digit BCD up/down counter wrapping between 00 and MAX.
module bcd2_updown
  import clock_pkg::*;
#(
  parameter bcd2_t MAX = 8'h59
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  inc,
  input  logic  dec,
  output bcd2_t value,
  output logic  carry_out
);

  bcd2_t value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc && !dec) begin
      if (value_q == MAX)
        value_d = 8'h00;
      else if (value_q[3:0] == 4'd9)
        value_d = {value_q[7:4] + 4'd1, 4'd0};
      else
        value_d = {value_q[7:4], value_q[3:0] + 4'd1};
    end else if (dec && !inc) begin
      if (value_q == 8'h00)
        value_d = MAX;
      else if (value_q[3:0] == 4'd0)
        value_d = {value_q[7:4] - 4'd1, 4'd9};
      else
        value_d = {value_q[7:4], value_q[3:0] - 4'd1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= 8'h00;
    else     value_q <= value_d;
  end

  assign value     = value_q;
  assign carry_out = inc & (value_q == MAX);

endmodule

// File: rtl/clock_set_ctrl.sv
// Timekeeping plus field-setting mode FSM with inactivity timeout back to RUN.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter bcd2_t HOUR_MAX  = 8'h23,
  parameter int    TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output bcd2_t      hh,
  output bcd2_t      mm,
  output bcd2_t      ss,
  output logic [1:0] blink_sel,
  output logic       setting
);

  localparam int TW = $clog2(TIMEOUT_S + 1);

  clk_mode_t     state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          any_btn, edit_inc, edit_dec;
  logic          hh_inc, hh_dec, mm_inc, mm_dec, ss_inc, ss_dec;
  logic          hh_carry, mm_carry, ss_carry;

  assign any_btn  = btn_mode | btn_inc | btn_dec;
  // A mode pulse swallows a simultaneous inc/dec.
  assign edit_inc = btn_inc & ~btn_mode;
  assign edit_dec = btn_dec & ~btn_mode;

  always_comb begin
    hh_inc = 1'b0; hh_dec = 1'b0;
    mm_inc = 1'b0; mm_dec = 1'b0;
    ss_inc = 1'b0; ss_dec = 1'b0;
    case (state_q)
      RUN: begin
        ss_inc = tick_1hz;
        mm_inc = ss_carry;
        hh_inc = mm_carry;
      end
      SET_HH: begin hh_inc = edit_inc; hh_dec = edit_dec; end
      SET_MM: begin mm_inc = edit_inc; mm_dec = edit_dec; end
      SET_SS: begin ss_inc = edit_inc; ss_dec = edit_dec; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    if (btn_mode) begin
      tmo_d = '0;
      case (state_q)
        RUN:     state_d = SET_HH;
        SET_HH:  state_d = SET_MM;
        SET_MM:  state_d = SET_SS;
        default: state_d = RUN;
      endcase
    end else if (state_q == RUN) begin
      tmo_d = '0;
    end else if (any_btn) begin
      tmo_d = '0;
    end else if (tick_1hz) begin
      // The tick that would make the count reach TIMEOUT_S exits immediately.
      if (tmo_q == TW'(TIMEOUT_S - 1)) begin
        state_d = RUN;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      tmo_q     <= '0;
      blink_sel <= BLINK_NONE;
      setting   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      blink_sel <= blink_code(state_d);
      setting   <= (state_d != RUN);
    end
  end

  bcd2_updown #(.MAX(8'h59)) u_ss (
    .clk(clk), .rst(rst), .inc(ss_inc), .dec(ss_dec), .value(ss), .carry_out(ss_carry)
  );

  bcd2_updown #(.MAX(8'h59)) u_mm (
    .clk(clk), .rst(rst), .inc(mm_inc), .dec(mm_dec), .value(mm), .carry_out(mm_carry)
  );

  bcd2_updown #(.MAX(HOUR_MAX)) u_hh (
    .clk(clk), .rst(rst), .inc(hh_inc), .dec(hh_dec), .value(hh), .carry_out(hh_carry)
  );

  logic unused_hh_carry;
  assign unused_hh_carry = hh_carry;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: vector table plus multi-cycle sequences.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic [7:0] hh, mm, ss;
  logic [1:0] blink_sel;
  logic       setting;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  clock_set_ctrl #(.HOUR_MAX(8'h23), .TIMEOUT_S(10)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
    .btn_inc(btn_inc), .btn_dec(btn_dec), .hh(hh), .mm(mm), .ss(ss),
    .blink_sel(blink_sel), .setting(setting)
  );

  // {rst,tick,mode,inc,dec} then expected {hh,mm,ss,blink_sel,setting}
  typedef struct packed {
    logic [4:0] in;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic [1:0] blink;
    logic       set;
  } vec_t;

  vec_t tbl[$];

  task automatic apply(input logic [4:0] in);
    {rst, tick_1hz, btn_mode, btn_inc, btn_dec} = in;
    @(posedge clk);
    #1;
    {rst, tick_1hz, btn_mode, btn_inc, btn_dec} = 5'b0;
  endtask

  task automatic check(input string name, input logic [26:0] exp);
    logic [26:0] got;
    got = {hh, mm, ss, blink_sel, setting};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got hh=%h mm=%h ss=%h blink=%b set=%b, expected hh=%h mm=%h ss=%h blink=%b set=%b",
               name, got[26:19], got[18:11], got[10:3], got[2:1], got[0],
               exp[26:19], exp[18:11], exp[10:3], exp[2:1], exp[0]);
    end else begin
      $display("ok   %s: hh=%h mm=%h ss=%h blink=%b set=%b", name, hh, mm, ss, blink_sel, setting);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  localparam logic [4:0] R = 5'b10000, T = 5'b01000, M = 5'b00100, I = 5'b00010, D = 5'b00001;

  initial begin
    // Reset, then count 60 seconds
    apply(R);
    check("reset", {8'h00, 8'h00, 8'h00, 2'b11, 1'b0});
    for (int i = 1; i <= 59; i++) begin
      apply(T);
      check($sformatf("tick%0d", i), {8'h00, 8'h00, to_bcd(i), 2'b11, 1'b0});
    end
    apply(T);
    check("tick60_carry", {8'h00, 8'h01, 8'h00, 2'b11, 1'b0});

    tbl.push_back({R,     8'h00, 8'h00, 8'h00, 2'b11, 1'b0});
    tbl.push_back({M,     8'h00, 8'h00, 8'h00, 2'b00, 1'b1});
    tbl.push_back({D,     8'h23, 8'h00, 8'h00, 2'b00, 1'b1});
    tbl.push_back({T,     8'h23, 8'h00, 8'h00, 2'b00, 1'b1});
    tbl.push_back({T,     8'h23, 8'h00, 8'h00, 2'b00, 1'b1});
    tbl.push_back({I,     8'h00, 8'h00, 8'h00, 2'b00, 1'b1});
    tbl.push_back({D,     8'h23, 8'h00, 8'h00, 2'b00, 1'b1});
    tbl.push_back({M,     8'h23, 8'h00, 8'h00, 2'b01, 1'b1});
    tbl.push_back({D,     8'h23, 8'h59, 8'h00, 2'b01, 1'b1});
    tbl.push_back({I,     8'h23, 8'h00, 8'h00, 2'b01, 1'b1});
    tbl.push_back({D,     8'h23, 8'h59, 8'h00, 2'b01, 1'b1});
    tbl.push_back({I | D, 8'h23, 8'h59, 8'h00, 2'b01, 1'b1});
    tbl.push_back({M,     8'h23, 8'h59, 8'h00, 2'b10, 1'b1});
    tbl.push_back({D,     8'h23, 8'h59, 8'h59, 2'b10, 1'b1});
    tbl.push_back({M,     8'h23, 8'h59, 8'h59, 2'b11, 1'b0});
    tbl.push_back({T,     8'h00, 8'h00, 8'h00, 2'b11, 1'b0});
    tbl.push_back({T,     8'h00, 8'h00, 8'h01, 2'b11, 1'b0});
    tbl.push_back({I,     8'h00, 8'h00, 8'h01, 2'b11, 1'b0});
    tbl.push_back({D,     8'h00, 8'h00, 8'h01, 2'b11, 1'b0});
    tbl.push_back({M | I, 8'h00, 8'h00, 8'h01, 2'b00, 1'b1});
    tbl.push_back({D,     8'h23, 8'h00, 8'h01, 2'b00, 1'b1});
    tbl.push_back({D,     8'h22, 8'h00, 8'h01, 2'b00, 1'b1});
    tbl.push_back({D,     8'h21, 8'h00, 8'h01, 2'b00, 1'b1});
    tbl.push_back({D,     8'h20, 8'h00, 8'h01, 2'b00, 1'b1});
    tbl.push_back({D,     8'h19, 8'h00, 8'h01, 2'b00, 1'b1});
    tbl.push_back({I,     8'h20, 8'h00, 8'h01, 2'b00, 1'b1});
    tbl.push_back({M | I, 8'h20, 8'h00, 8'h01, 2'b01, 1'b1});
    tbl.push_back({I,     8'h20, 8'h01, 8'h01, 2'b01, 1'b1});
    tbl.push_back({R | I, 8'h00, 8'h00, 8'h00, 2'b11, 1'b0});

    foreach (tbl[k]) begin
      apply(tbl[k].in);
      check($sformatf("vec%0d", k),
            {tbl[k].hh, tbl[k].mm, tbl[k].ss, tbl[k].blink, tbl[k].set});
    end

    // Timeout from SET_SS: the 10th idle tick returns to RUN
    apply(M); apply(M); apply(M);
    check("enter_set_ss", {8'h00, 8'h00, 8'h00, 2'b10, 1'b1});
    for (int i = 1; i <= 9; i++) apply(T);
    check("tmo_tick9_still_set", {8'h00, 8'h00, 8'h00, 2'b10, 1'b1});
    apply(T);
    check("tmo_tick10_run", {8'h00, 8'h00, 8'h00, 2'b11, 1'b0});
    apply(T);
    check("run_resumes", {8'h00, 8'h00, 8'h01, 2'b11, 1'b0});

    // A button pulse restarts the timeout count
    apply(M);
    for (int i = 1; i <= 5; i++) apply(T);
    apply(I);
    check("tmo_clear_inc", {8'h01, 8'h00, 8'h01, 2'b00, 1'b1});
    for (int i = 1; i <= 9; i++) apply(T);
    check("tmo_restart_tick9", {8'h01, 8'h00, 8'h01, 2'b00, 1'b1});
    apply(T);
    check("tmo_restart_tick10", {8'h01, 8'h00, 8'h01, 2'b11, 1'b0});

    // Reset in the middle of a full carry chain
    apply(R);
    apply(M); apply(D); apply(M); apply(D); apply(M); apply(D); apply(M);
    check("preload_235959", {8'h23, 8'h59, 8'h59, 2'b11, 1'b0});
    apply(R | T);
    check("rst_mid_carry", {8'h00, 8'h00, 8'h00, 2'b11, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
